mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one single-ported unified memory between the pipeline's fetch stage (instruction port) and memory stage (data port). It sits between the pipelined datapath and the external memory model. It sequences one memory transaction at a time and returns per-port ready pulses and stall requests to the hazard logic. The data port has priority, and a starvation guard limits how long the fetch port can be locked out.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive data grants allowed while `i_req` is pending before fetch is forced.
- `AW`, default 32: address width.
- `DW`, default 32: data width (fixed byte lanes, `DW/8` = 4).
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch request; held until `i_ready`.
- `i_addr`  in  AW  fetch address; word aligned, stable while `i_req`.
- `i_rdata`  out  DW  fetched word; valid only when `i_ready`.
- `i_ready`  out  1  one-cycle completion pulse for fetch.
- `d_req`  in  1  data request; held until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_size`  in  2  00 word, 01 half, 10 byte, 11 reserved.
- `d_addr`  in  AW  data byte address.
- `d_wdata`  in  DW  store data, right-aligned (byte in [7:0], half in [15:0]).
- `d_rdata`  out  DW  raw loaded word (memout does the extension); valid when `d_ready`.
- `d_ready`  out  1  one-cycle completion pulse for data.
- `d_err`  out  1  pulses with `d_ready` on a misaligned or reserved-size access.
- `m_req`  out  1  memory request; held until `m_ack`.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  AW  word address: the requester's address with [1:0] forced to 0.
- `m_wdata`  out  DW  store data replicated into the addressed lanes.
- `m_be`  out  4  byte enables. Stores use the enables for the access size. Loads use 4'b1111.
- `m_rdata`  in  DW  memory read data; valid in the `m_ack` cycle.
- `m_ack`  in  1  memory completion. It may arrive in the first `m_req` cycle or any cycle after.
- `stall_if`  out  1  `i_req & ~i_ready`, combinational.
- `stall_mem`  out  1  `d_req & ~d_ready`, combinational.

## Operation
- FSM states:
  - IDLE
  - BUSY_I
  - BUSY_D
  - RESP_I
  - RESP_D
- IDLE arbitration, evaluated each cycle:
  - If `d_req` is set and `starve_cnt < STARVE_LIMIT`, take BUSY_D. This applies even when `i_req` is also set.
  - Otherwise, if `i_req` is set, take BUSY_I.
  - Otherwise, remain in IDLE.
- On entry to BUSY_x, the winning port's address, data, size and direction are latched into a transaction register. The memory-side outputs are driven only from that register.
- Misalign or reserved check, on the data grant:
  - It is an error if `d_size`=01 with `d_addr[0]`=1, if `d_size`=00 with `d_addr[1:0]`≠0, or if `d_size`=11.
  - On error, no memory access is made. The FSM goes IDLE→RESP_D with `d_err` set and `d_rdata`=0.
- BUSY_x: `m_req`=1. On `m_ack`, `m_rdata` is captured into the response register and the FSM moves to RESP_x.
- RESP_x: the matching `x_ready` pulses for exactly one cycle, with `x_rdata` taken from the response register. The next state is IDLE.
- `starve_cnt`:
  - Increments on each data grant made while `i_req`=1, saturating at STARVE_LIMIT.
  - Clears on any fetch grant, and whenever `i_req`=0 in IDLE.
- Byte enables for stores:
  - Byte: `m_be` = 1 << addr[1:0].
  - Half: `m_be` = 4'b0011 << addr[1:0].
  - Word: `m_be` = 4'b1111.
- Store data: `m_wdata` holds the byte replicated ×4 for byte stores, and the half replicated ×2 for half stores.
- Reset values (asynchronous, immediate): state IDLE, `starve_cnt` 0, transaction and response registers 0. Therefore `m_req`, `m_we`, `i_ready`, `d_ready` and `d_err` are all 0, and `m_be`, `m_addr`, `m_wdata`, `i_rdata` and `d_rdata` are all 0.

## Timing
- Minimum latency is 3 cycles from request to ready when `m_ack` arrives in the first BUSY cycle:
  - cycle 0: IDLE grants.
  - cycle 1: BUSY, ack.
  - cycle 2: RESP, ready.
- A misaligned access takes 2 cycles: IDLE, then RESP_D.
- Back-to-back transactions leave one IDLE cycle between a RESP and the next BUSY.
- A requester must keep its `req` high until it sees `ready`. In the cycle after `ready` it may either drop `req` or re-assert it for a new transaction.
- A requester dropping `req` during BUSY does not abort the transaction. The transaction completes and `ready` still pulses.
- `m_ack` outside BUSY is ignored.
- Reset asserted mid-transaction drops `m_req` in the same cycle, and the transaction is abandoned.

## Structure
- Package `mem_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D);
  - the size encodings SZ_WORD, SZ_HALF, SZ_BYTE and SZ_RSVD;
  - the default for STARVE_LIMIT.
- One sub-module, `be_gen`: combinational, taking size, addr[1:0] and wdata and producing `m_be`, the replicated `m_wdata` and the misalign flag.

## Test plan
- Fetch only: `i_req`, `i_addr`=0x0040_0004, memory acks on the first cycle → `m_addr`=0x0040_0004, `m_be`=4'b1111, and `i_ready` pulses in the third cycle with `i_rdata`=`m_rdata`.
- Simultaneous requests in IDLE, `i_req`=`d_req`=1 → data is granted first and fetch afterwards. `stall_if` stays 1 until `i_ready`.
- Store byte `d_addr`=0x1003, `d_wdata`=0xA5 → `m_be`=4'b1000, `m_wdata`=0xA5A5A5A5, `m_we`=1.
- Store half at 0x1001 → `d_err`=1 and `d_ready` pulse after 2 cycles, with no `m_req` ever raised.
- Continuous `d_req` with `i_req` held, STARVE_LIMIT=4 → the sequence is 4 data grants, then 1 fetch grant, and the counter then restarts.
- `m_ack` delayed 5 cycles with reset asserted in the third BUSY cycle → `m_req` and `d_ready` drop to 0 in that same cycle, the FSM is in IDLE after reset release, and no ready pulse occurs.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared FSM states, access-size encodings and defaults for mem_arbiter
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} arb_state_t;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/mem_arbiter_be_gen.sv
// be_gen: store byte enables, lane replication of store data and alignment check
module be_gen
    import mem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    size,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] wdata,
    output logic [3:0]    be,
    output logic [DW-1:0] wdata_rep,
    output logic          misalign
);
    always_comb begin
        be        = size == SZ_BYTE ? 4'b0001 << addr : size == SZ_HALF ? 4'b0011 << addr : 4'b1111;
        wdata_rep = size == SZ_BYTE ? {(DW/8){wdata[7:0]}} : size == SZ_HALF ? {(DW/16){wdata[15:0]}} : wdata;
        misalign  = size == SZ_RSVD || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and data ports,
// data first, with a starvation guard that forces a fetch after STARVE_LIMIT data grants
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          d_err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [3:0]    m_be,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          stall_if,
    output logic          stall_mem
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    arb_state_t    state;
    logic [CW-1:0] starve_cnt;
    logic          t_we, err, misalign, d_win;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, resp, wdata_rep;
    logic [3:0]    t_be, be;
    be_gen #(.DW(DW)) u_be_gen (
        .size(d_size), .addr(d_addr[1:0]), .wdata(d_wdata),
        .be(be), .wdata_rep(wdata_rep), .misalign(misalign)
    );
    assign d_win = d_req && starve_cnt < CW'(STARVE_LIMIT);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            t_we       <= 1'b0;
            t_addr     <= '0;
            t_wdata    <= '0;
            t_be       <= '0;
            resp       <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_win) begin
                        t_we    <= d_we;
                        t_addr  <= d_addr & ~AW'(3);
                        t_wdata <= wdata_rep;
                        t_be    <= d_we ? be : 4'b1111;
                        err     <= misalign;
                        resp    <= '0;
                        state   <= misalign ? RESP_D : BUSY_D;
                    end else if (i_req) begin
                        t_we    <= 1'b0;
                        t_addr  <= i_addr & ~AW'(3);
                        t_wdata <= '0;
                        t_be    <= 4'b1111;
                        err     <= 1'b0;
                        state   <= BUSY_I;
                    end
                    // d_win already implies the count is below the limit, so +1 saturates naturally
                    starve_cnt <= d_win && i_req ? starve_cnt + 1'b1 : '0;
                end
                BUSY_I, BUSY_D: begin
                    if (m_ack) begin
                        resp  <= m_rdata;
                        state <= state == BUSY_I ? RESP_I : RESP_D;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign m_req     = state == BUSY_I || state == BUSY_D;
    assign m_we      = m_req & t_we;
    assign m_addr    = t_addr;
    assign m_wdata   = t_wdata;
    assign m_be      = t_be;
    assign i_ready   = state == RESP_I;
    assign d_ready   = state == RESP_D;
    assign d_err     = d_ready & err;
    assign i_rdata   = resp;
    assign d_rdata   = resp;
    assign stall_if  = i_req & ~i_ready;
    assign stall_mem = d_req & ~d_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a word-level memory model
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    logic        clk = 1'b0, reset = 1'b0;
    logic        i_req = 0, d_req = 0, d_we = 0, m_ack = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
    logic [1:0]  d_size = 0;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ready, d_ready, d_err, m_req, m_we, stall_if, stall_mem;
    logic [3:0]  m_be;
    logic [31:0] mem [64];
    logic [31:0] gold [64];
    int          total = 0, bad = 0, ack_lat = 0, wait_n = 0;
    logic        mreq_q = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata), .m_ack(m_ack), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // Memory model: acks after ack_lat extra cycles (random when negative), stray acks when idle
    always @(negedge clk) begin
        if (m_req) begin
            if (!mreq_q) wait_n = ack_lat < 0 ? $urandom_range(0, 3) : ack_lat;
            else wait_n--;
            m_ack = wait_n == 0;
            m_rdata = m_ack ? mem[m_addr[7:2]] : $urandom;
            if (m_ack && m_we)
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem[m_addr[7:2]][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
            m_ack = $urandom_range(0, 3) == 0;
            m_rdata = $urandom;
        end
        mreq_q = m_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic [1:0] sz, input logic [1:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd0 && a != 0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] sz,
                                          input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        mask = sz == 2'd2 ? 32'hFF : sz == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
        return (old & ~(mask << (8 * a))) | ((wd & mask) << (8 * a));
    endfunction

    task automatic i_txn(input logic [31:0] a, output int cyc, output logic [31:0] rd, ma,
                         output logic [3:0] be);
        i_req = 1; i_addr = a; cyc = 0; ma = '0; be = '0;
        do begin
            @(posedge clk); #1; cyc++;
            if (m_req) begin ma = m_addr; be = m_be; end
        end while (!i_ready && cyc < 50);
        rd = i_rdata;
        i_req = 0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic d_txn(input logic we, input logic [1:0] sz, input logic [31:0] a, wd,
                         output int cyc, output logic [31:0] rd, output logic er,
                         output logic [3:0] be, output logic [31:0] mw, ma,
                         output logic mwe, output logic sawm);
        d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        cyc = 0; sawm = 0; be = '0; mw = '0; ma = '0; mwe = 0;
        do begin
            @(posedge clk); #1; cyc++;
            if (m_req) begin sawm = 1; be = m_be; mw = m_wdata; ma = m_addr; mwe = m_we; end
        end while (!d_ready && cyc < 50);
        rd = d_rdata; er = d_err;
        d_req = 0;
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        int          cyc, n, nd, ni;
        logic [31:0] rd, mw, ma;
        logic [3:0]  be;
        logic        er, mwe, sawm, ok, seen, ee;
        logic [5:0]  idx;
        string       order;
        for (int i = 0; i < 64; i++) begin mem[i] = $urandom; gold[i] = mem[i]; end
        #1 reset = 1;
        #2;
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_d_err", d_err, 0);
        chk("rst_m_be", m_be, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(negedge clk); @(negedge clk); reset = 0;
        @(negedge clk);

        ack_lat = 0;
        i_txn(32'h0040_0004, cyc, rd, ma, be);
        chk("fetch_lat", cyc, 2);
        chk("fetch_addr", ma, 32'h0040_0004);
        chk("fetch_be", be, 4'b1111);
        chk("fetch_data", rd, gold[1]);

        d_txn(1, SZ_BYTE, 32'h1003, 32'hA5, cyc, rd, er, be, mw, ma, mwe, sawm);
        gold[0] = merge(gold[0], SZ_BYTE, 2'd3, 32'hA5);
        chk("sb_lat", cyc, 2);
        chk("sb_be", be, 4'b1000);
        chk("sb_wdata", mw, 32'hA5A5_A5A5);
        chk("sb_we", mwe, 1);
        chk("sb_addr", ma, 32'h1000);
        chk("sb_err", er, 0);

        d_txn(1, SZ_HALF, 32'h1002, 32'h1234_BEEF, cyc, rd, er, be, mw, ma, mwe, sawm);
        gold[0] = merge(gold[0], SZ_HALF, 2'd2, 32'h1234_BEEF);
        chk("sh_be", be, 4'b1100);
        chk("sh_wdata", mw, 32'hBEEF_BEEF);

        d_txn(0, SZ_WORD, 32'h1000, 32'h0, cyc, rd, er, be, mw, ma, mwe, sawm);
        chk("lw_data", rd, gold[0]);
        chk("lw_be", be, 4'b1111);
        chk("lw_we", mwe, 0);

        d_txn(1, SZ_HALF, 32'h1001, 32'h5555, cyc, rd, er, be, mw, ma, mwe, sawm);
        chk("mis_lat", cyc, 1);
        chk("mis_err", er, 1);
        chk("mis_no_mreq", sawm, 0);
        chk("mis_rdata", rd, 0);

        ack_lat = -1; order = ""; ok = 1;
        i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_size = SZ_WORD; d_addr = 32'h10;
        for (int c = 0; c < 100 && order.len() < 2; c++) begin
            @(posedge clk); #1;
            if (!i_ready && stall_if !== 1'b1) ok = 0;
            if (d_req && !d_ready && stall_mem !== 1'b1) ok = 0;
            if (d_ready) begin order = {order, "D"}; d_req = 0; end
            if (i_ready) begin order = {order, "I"}; chk("sim_stall_if_end", stall_if, 0); i_req = 0; end
        end
        total++;
        assert (order == "DI") else begin bad++; $error("FAIL sim_order: got %s want DI", order); end
        chk("sim_stall", ok, 1);
        @(negedge clk); @(negedge clk); @(negedge clk);

        order = "";
        i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_size = SZ_WORD; d_addr = 32'h10;
        for (int c = 0; c < 300 && order.len() < 10; c++) begin
            @(posedge clk); #1;
            if (d_ready) order = {order, "D"};
            if (i_ready) order = {order, "I"};
        end
        i_req = 0; d_req = 0;
        total++;
        assert (order == "DDDDIDDDDI") else begin
            bad++; $error("FAIL starve_order: got %s want DDDDIDDDDI", order);
        end
        @(negedge clk); @(negedge clk); @(negedge clk);

        ack_lat = 5; n = 0;
        d_req = 1; d_we = 0; d_size = SZ_WORD; d_addr = 32'h40;
        do begin @(posedge clk); #1; n++; end while (!m_req && n < 20);
        @(posedge clk); #1; @(posedge clk); #1;
        chk("rst_busy_before", m_req, 1);
        reset = 1; #1;
        chk("rst_mid_mreq", m_req, 0);
        chk("rst_mid_dready", d_ready, 0);
        d_req = 0;
        @(negedge clk); @(negedge clk); reset = 0;
        chk("rst_mid_state", dut.state, IDLE);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (i_ready || d_ready || m_req) seen = 1;
        end
        chk("rst_mid_quiet", seen, 0);

        ack_lat = -1; nd = 0; ni = 0;
        for (int c = 0; c < 6000 && (nd < 60 || ni < 60); c++) begin
            @(posedge clk); #1;
            if (d_ready) begin
                idx = d_addr[7:2];
                ee = exp_err(d_size, d_addr[1:0]);
                chk("rnd_err", d_err, ee);
                if (ee) chk("rnd_errdata", d_rdata, 0);
                else if (d_we) gold[idx] = merge(gold[idx], d_size, d_addr[1:0], d_wdata);
                else chk("rnd_load", d_rdata, gold[idx]);
                nd++; d_req = 0;
            end
            if (i_ready) begin
                chk("rnd_fetch", i_rdata, gold[i_addr[7:2]]);
                ni++; i_req = 0;
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1; d_we = 1'($urandom); d_size = 2'($urandom);
                d_addr = $urandom & 32'h0000_30FF; d_wdata = $urandom;
            end
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1; i_addr = $urandom & 32'h00FF_FFFC;
            end
        end
        chk("rnd_done", nd >= 60 && ni >= 60, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
